// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: accepts a parallel word over valid/ready, shifts it out
// MSB-first on sout at one bit per DIV clocks while capturing N bits from
// sin, then presents the captured word with a one-cycle out_valid pulse.
module shift_seq_ctrl #(
    parameter int N   = 4,
    parameter int DIV = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sin,
    output logic         sout,
    output logic         sframe,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    output logic         busy
);

    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BCNT_LAST = BW'(N - 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   sr_reg, sr_next;
    logic [BW-1:0]  bcnt_reg, bcnt_next;
    logic [DW-1:0]  dcnt_reg, dcnt_next;
    logic [N-1:0]   out_data_reg, out_data_next;
    logic           out_valid_reg, out_valid_next;

    logic           bit_end;
    logic           word_end;
    logic           accept;
    logic [N-1:0]   shifted;

    // Shift register moved one place toward the MSB with sin entering at bit 0;
    // this is both the next shift-register value and the captured word.
    assign shifted[0] = sin;
    for (genvar gi = 1; gi < N; gi++) begin : g_shift
        assign shifted[gi] = sr_reg[gi-1];
    end

    assign bit_end  = (state_reg == SHIFT) && (dcnt_reg == DCNT_LAST);
    assign word_end = bit_end && (bcnt_reg == BCNT_LAST);

    // Ready depends only on registered state, so there is no path from in_valid.
    assign in_ready = (state_reg == IDLE) || word_end;
    assign accept   = in_valid && in_ready;

    assign sframe    = (state_reg == SHIFT);
    assign busy      = sframe;
    assign sout      = (state_reg == SHIFT) && sr_reg[N-1];
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;

    // Next-state logic: divider/bit counting, word completion and accept.
    always_comb begin
        state_next     = state_reg;
        sr_next        = sr_reg;
        bcnt_next      = bcnt_reg;
        dcnt_next      = dcnt_reg;
        out_data_next  = out_data_reg;
        out_valid_next = 1'b0;

        if (state_reg == SHIFT) begin
            if (bit_end) begin
                dcnt_next = '0;
                sr_next   = shifted;
                bcnt_next = bcnt_reg + BW'(1);
            end else begin
                dcnt_next = dcnt_reg + DW'(1);
            end

            if (word_end) begin
                out_data_next  = shifted;
                out_valid_next = 1'b1;
                bcnt_next      = '0;
                state_next     = IDLE;
            end
        end

        // A word accepted on the last bit edge overrides the return to IDLE,
        // giving gapless back-to-back framing.
        if (accept) begin
            sr_next    = in_data;
            bcnt_next  = '0;
            dcnt_next  = '0;
            state_next = SHIFT;
        end
    end

    // State register with synchronous active-low reset; a partial word is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            sr_reg        <= '0;
            bcnt_reg      <= '0;
            dcnt_reg      <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sr_reg        <= sr_next;
            bcnt_reg      <= bcnt_next;
            dcnt_reg      <= dcnt_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
        end
    end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencer that owns a serial shift-register datapath. It accepts a parallel word over a valid/ready handshake, shifts it out MSB-first on `sout` at a programmable bit rate, and simultaneously captures N bits from `sin`. It presents the captured word as a one-cycle parallel result. It sits between a parallel producer/consumer and a serial line or SISO register chain.

## Interface
- `N`, default 4: word width in bits; N ≥ 2.
- `DIV`, default 1: clock cycles per bit period; DIV ≥ 1.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous, active-low (`rst`=0 at a rising edge of `clk` resets).
- `in_data` input N: parallel word to transmit.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block accepts a word this cycle.
- `sin` input 1: serial receive bit.
- `sout` output 1: serial transmit bit; 0 when not framing.
- `sframe` output 1: high while a word is being shifted.
- `out_data` output N: last captured word; holds until the next capture.
- `out_valid` output 1: one-cycle pulse when `out_data` is updated.
- `busy` output 1: equals `sframe`.

## Operation
- States:
  - IDLE: no word in flight.
  - SHIFT: word in flight.
- Internal registers:
  - shift register `sr[N-1:0]`.
  - bit counter `bcnt` (0..N-1), width `$clog2(N)`, minimum 1.
  - divider counter `dcnt` (0..DIV-1).
- Accept condition: `in_valid && in_ready` at a rising edge. On accept:
  - `sr <= in_data`, `bcnt <= 0`, `dcnt <= 0`, state goes to SHIFT.
- `in_ready` is combinational: 1 in IDLE, or in SHIFT when `bcnt==N-1 && dcnt==DIV-1` (last cycle of the word). It is 0 otherwise.
- `sout` = `sr[N-1]` in SHIFT, 0 in IDLE. `sframe` = (state==SHIFT).
- Each SHIFT cycle:
  - If `dcnt != DIV-1`: `dcnt++` only.
  - If `dcnt == DIV-1` (bit boundary): `dcnt <= 0`, `sr <= {sr[N-2:0], sin}`, `bcnt++`. `sin` is sampled only at this edge.
- Word end is the bit boundary with `bcnt==N-1`. At that edge:
  - `out_data <= {sr[N-2:0], sin}`.
  - `out_valid <= 1` for exactly one cycle.
  - If an accept occurs at the same edge, the new word loads and the state stays SHIFT with no gap. Otherwise the state returns to IDLE.
- `in_valid` while `in_ready`=0 is ignored. `in_data` is not sampled and no state changes.
- There is no backpressure on `out_valid`; the consumer must take the word on the pulse.
- Reset:
  - state=IDLE, `sr`=0, `bcnt`=0, `dcnt`=0, `out_data`=0, `out_valid`=0.
  - Resulting outputs: `sout`=0, `sframe`=0, `busy`=0, `in_ready`=1 (once `rst`=1).
- Reset mid-word discards the partial word. No `out_valid` is produced for it.

## Timing
- Accept at edge E0. Bit k (k=0..N-1, MSB first) appears on `sout` from E0+k·DIV to E0+(k+1)·DIV.
- `sin` bit k is sampled at edge E0+(k+1)·DIV.
- `out_valid` is high in the cycle after edge E0+N·DIV. Accept-to-result latency is N·DIV cycles.
- Back-to-back words give continuous `sframe`=1 with a throughput of one word per N·DIV cycles.
- Captured word ordering: the first `sin` bit sampled lands in `out_data[N-1]`.
- The `in_ready`→`in_valid` path is combinational; there is no combinational path from `in_valid` to `in_ready`.

## Test plan
- **Basic loopback.** N=4, DIV=1, `sin` tied to `sout`, send `in_data`=4'b1011 → `sout` sequence 1,0,1,1 on the 4 cycles after accept. `sframe` is high for exactly 4 cycles. `out_valid` pulses once with `out_data`=4'b1011 on cycle 4 after accept.
- **Back-to-back.** N=4, DIV=1, `in_valid` held high with words 4'hA then 4'h5 → second accept occurs at the last-bit edge of the first word. `sout` is 1,0,1,0,0,1,0,1 with `sframe` never dropping. Two `out_valid` pulses occur 4 cycles apart.
- **Divided rate.** N=4, DIV=3, `in_data`=4'b1100, `sin` driven 0,1,1,0 per bit period → each `sout` bit is held 3 cycles. `out_data`=4'b0110 with `out_valid` 12 cycles after accept. `in_ready`=0 except on cycle 12.
- **Busy ignore.** N=4, DIV=1, pulse `in_valid` with 4'hF two cycles after accepting 4'h3 → the 4'hF pulse is ignored. Only 0,0,1,1 is shifted, with one `out_valid`.
- **Reset mid-word.** N=4, DIV=2, drive `rst`=0 for one edge at bit 2 → next cycle `sout`=0, `sframe`=0, `in_ready`=1, `out_data`=0. No `out_valid` occurs, and a fresh word sends correctly afterwards.
- **Independent receive.** N=8, DIV=1, `in_data`=8'h00, `sin` driven 1,0,0,0,0,0,0,1 → `out_data`=8'h81. `sout` stays 0 throughout.
